// File: rtl/wb_text_buffer.sv
// wb_text_buffer: Wishbone text-mode character/attribute RAM with a clear/scroll engine.
// Define CURSOR_OVERLAY_EN to highlight the cursor cell on the video port.
module wb_text_buffer #(
    parameter int unsigned COLS     = 80,
    parameter int unsigned ROWS     = 30,
    parameter int unsigned ADDR_W   = 12,
    parameter logic [7:0]  DEF_ATTR = 8'h07
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wb_adr_i,
    input  logic [7:0]        wb_dat_i,
    output logic [7:0]        wb_dat_o,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    output logic              wb_ack_o,
    input  logic [ADDR_W-1:0] video_addr,
    output logic [7:0]        video_char_data,
    output logic [7:0]        video_attr_data,
    output logic              busy
);
    localparam int unsigned     Cells  = COLS * ROWS;
    localparam int unsigned     IdxW   = ADDR_W + 1;
    localparam logic [IdxW-1:0] CellsI = IdxW'(Cells);
    localparam logic [15:0]     CellsP = 16'(Cells);
    localparam logic [7:0]      ColsB  = 8'(COLS);
    localparam logic [7:0]      RowsB  = 8'(ROWS);
    localparam logic [7:0]      Blank  = 8'h20;

    typedef enum logic [1:0] {StIdle, StClear, StCopy, StFill} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   cnt_q, cnt_d, shift_q, shift_d, copy_len;
    logic [7:0]        eattr_q, eattr_d, pipe_char_q, pipe_char_d, pipe_attr_q, pipe_attr_d;
    logic              ack_q, ack_d;
    logic [7:0]        dat_q, dat_d;
    logic [2:1]        ctrl_q, ctrl_d;
    logic [6:0]        curx_q, curx_d;
    logic [4:0]        cury_q, cury_d;
    logic [7:0]        attr_q, attr_d;
    logic [15:0]       ptr_q, ptr_d;
    logic [7:0]        vchar_q, vattr_q;

    // Planes hold data XOR-ed with the blank cell, so a zeroed RAM reads as 0x20/DEF_ATTR.
    logic [7:0] char_mem [Cells];
    logic [7:0] attr_mem [Cells];

    logic [ADDR_W-1:0] cur_cell, ptr_cell, src_cell, bus_addr, eng_addr, mem_addr;
    logic              ptr_ok, req_held, accept, start_clear, start_scroll;
    logic [7:0]        scroll_n, bus_char, bus_attr, eng_attr, mem_char, mem_attr;
    logic              bus_char_we, bus_attr_we, eng_we, char_we, attr_we;
    logic              unused_adr;

    assign busy       = (state_q != StIdle);
    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign unused_adr = ^wb_adr_i[7:4];
    assign cur_cell   = ADDR_W'(32'(cury_q) * COLS + 32'(curx_q));
    assign ptr_cell   = ptr_q[ADDR_W-1:0];
    assign ptr_ok     = (ptr_q < CellsP);
    assign src_cell   = ADDR_W'(cnt_q + shift_q);
    assign copy_len   = CellsI - shift_q;
    assign req_held   = busy && (wb_adr_i[3:0] inside {4'h0, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA});
    assign accept     = wb_cyc_i && wb_stb_i && !ack_q && !req_held;

    always_comb begin
        ack_d        = accept;
        dat_d        = dat_q;
        ctrl_d       = ctrl_q;
        curx_d       = curx_q;
        cury_d       = cury_q;
        attr_d       = attr_q;
        ptr_d        = ptr_q;
        start_clear  = 1'b0;
        start_scroll = 1'b0;
        scroll_n     = 8'd0;
        bus_char_we  = 1'b0;
        bus_attr_we  = 1'b0;
        bus_addr     = cur_cell;
        bus_char     = wb_dat_i;
        bus_attr     = wb_dat_i;
        if (accept) begin
            case (wb_adr_i[3:0])
                4'h0: if (wb_we_i) begin
                    ctrl_d      = wb_dat_i[2:1];
                    start_clear = wb_dat_i[0];
                end else dat_d = {busy, 4'b0, ctrl_q, 1'b0};
                4'h1: if (wb_we_i) curx_d = (wb_dat_i >= ColsB) ? 7'(COLS - 1) : wb_dat_i[6:0];
                      else dat_d = {1'b0, curx_q};
                4'h2: if (wb_we_i) cury_d = (wb_dat_i >= RowsB) ? 5'(ROWS - 1) : wb_dat_i[4:0];
                      else dat_d = {3'b0, cury_q};
                4'h3: if (wb_we_i) attr_d = wb_dat_i;
                      else dat_d = attr_q;
                4'h4: if (wb_we_i) begin
                    bus_char_we = 1'b1;
                    bus_attr_we = 1'b1;
                    bus_attr    = attr_q;
                    if (curx_q < 7'(COLS - 1)) begin
                        curx_d = curx_q + 7'd1;
                    end else begin
                        curx_d = '0;
                        if (cury_q < 5'(ROWS - 1)) begin
                            cury_d = cury_q + 5'd1;
                        end else if (ctrl_q[2]) begin
                            start_scroll = 1'b1;
                            scroll_n     = 8'd1;
                        end
                    end
                end else dat_d = char_mem[cur_cell] ^ Blank;
                4'h5: if (wb_we_i) bus_attr_we = 1'b1;
                      else dat_d = attr_mem[cur_cell] ^ DEF_ATTR;
                4'h6: if (wb_we_i) ptr_d[15:8] = wb_dat_i;
                      else dat_d = ptr_q[15:8];
                4'h7: if (wb_we_i) ptr_d[7:0] = wb_dat_i;
                      else dat_d = ptr_q[7:0];
                4'h8, 4'h9: begin
                    bus_addr = ptr_cell;
                    dat_d    = wb_we_i ? dat_q : 8'h00;
                    if (ptr_ok) begin
                        ptr_d = ptr_q + 16'd1;
                        if (wb_we_i) begin
                            bus_char_we = !wb_adr_i[0];
                            bus_attr_we = wb_adr_i[0];
                        end else begin
                            dat_d = wb_adr_i[0] ? (attr_mem[ptr_cell] ^ DEF_ATTR)
                                                : (char_mem[ptr_cell] ^ Blank);
                        end
                    end
                end
                4'hA: if (wb_we_i) begin
                    start_scroll = (wb_dat_i != 8'd0);
                    scroll_n     = wb_dat_i;
                end else dat_d = 8'h00;
                default: if (!wb_we_i) dat_d = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        eattr_d     = eattr_q;
        pipe_char_d = pipe_char_q;
        pipe_attr_d = pipe_attr_q;
        eng_we      = 1'b0;
        eng_addr    = cnt_q[ADDR_W-1:0];
        mem_char    = Blank;
        eng_attr    = eattr_q;
        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                eattr_d = attr_q;
                if (start_clear || (start_scroll && scroll_n >= RowsB)) begin
                    state_d = StClear;
                end else if (start_scroll) begin
                    state_d = StCopy;
                    shift_d = IdxW'(32'(scroll_n) * COLS);
                end
            end
            StClear, StFill: begin
                eng_we = 1'b1;
                cnt_d  = cnt_q + IdxW'(1);
                if (cnt_q == CellsI - IdxW'(1)) state_d = StIdle;
            end
            StCopy: begin
                // Read source at count k, write destination k-1 from the pipeline register.
                if (cnt_q != copy_len) begin
                    pipe_char_d = char_mem[src_cell] ^ Blank;
                    pipe_attr_d = attr_mem[src_cell] ^ DEF_ATTR;
                    cnt_d       = cnt_q + IdxW'(1);
                end else begin
                    state_d = StFill;
                end
                if (cnt_q != '0) begin
                    eng_we   = 1'b1;
                    eng_addr = ADDR_W'(cnt_q - IdxW'(1));
                    mem_char = pipe_char_q;
                    eng_attr = pipe_attr_q;
                end
            end
        endcase
    end

    assign char_we  = busy ? eng_we : bus_char_we;
    assign attr_we  = busy ? eng_we : bus_attr_we;
    assign mem_addr = busy ? eng_addr : bus_addr;
    assign mem_attr = busy ? eng_attr : bus_attr;

    always_ff @(posedge clk) begin
        if (char_we) char_mem[mem_addr] <= (busy ? mem_char : bus_char) ^ Blank;
        if (attr_we) attr_mem[mem_addr] <= mem_attr ^ DEF_ATTR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            eattr_q     <= DEF_ATTR;
            pipe_char_q <= Blank;
            pipe_attr_q <= DEF_ATTR;
            ack_q       <= 1'b0;
            dat_q       <= 8'h00;
            ctrl_q      <= '0;
            curx_q      <= '0;
            cury_q      <= '0;
            attr_q      <= DEF_ATTR;
            ptr_q       <= '0;
            vchar_q     <= Blank;
            vattr_q     <= DEF_ATTR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            eattr_q     <= eattr_d;
            pipe_char_q <= pipe_char_d;
            pipe_attr_q <= pipe_attr_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            ctrl_q      <= ctrl_d;
            curx_q      <= curx_d;
            cury_q      <= cury_d;
            attr_q      <= attr_d;
            ptr_q       <= ptr_d;
            if ({1'b0, video_addr} < CellsI) begin
                vchar_q <= char_mem[video_addr] ^ Blank;
                vattr_q <= attr_mem[video_addr] ^ DEF_ATTR;
            end else begin
                vchar_q <= Blank;
                vattr_q <= DEF_ATTR;
            end
        end
    end

    assign video_char_data = vchar_q;

`ifdef CURSOR_OVERLAY_EN
    logic [ADDR_W-1:0] vaddr_q;

    always_ff @(posedge clk) begin
        if (rst) vaddr_q <= '0;
        else     vaddr_q <= video_addr;
    end

    assign video_attr_data = (ctrl_q[1] && vaddr_q == cur_cell) ? {vattr_q[3:0], vattr_q[7:4]}
                                                                : vattr_q;
`else
    assign video_attr_data = vattr_q;
`endif

endmodule

// File: tb/tb_wb_text_buffer.sv
// Directed bench for wb_text_buffer: register table, scroll-on-wrap, clear stall,
// PTR boundary, multi-line scroll with reset abort, cursor overlay.
module tb_wb_text_buffer;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
    logic [11:0] video_addr;
    logic [7:0]  video_char_data, video_attr_data;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    wb_text_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .wb_adr_i        (wb_adr_i),
        .wb_dat_i        (wb_dat_i),
        .wb_dat_o        (wb_dat_o),
        .wb_cyc_i        (wb_cyc_i),
        .wb_stb_i        (wb_stb_i),
        .wb_we_i         (wb_we_i),
        .wb_ack_o        (wb_ack_o),
        .video_addr      (video_addr),
        .video_char_data (video_char_data),
        .video_attr_data (video_attr_data),
        .busy            (busy)
    );

    typedef struct {
        logic       we;
        logic [3:0] adr;
        logic [7:0] dat;   // write data, or expected read data
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [3:0] adr, input logic [7:0] dat,
                             output logic [7:0] rdat, output int waited);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {4'h0, adr};
        wb_dat_i = dat;
        waited   = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!wb_ack_o && waited < 5000);
        if (!wb_ack_o) begin
            checks++;
            errors++;
            $display("FAIL wb_ack_timeout: offset %0h no ack after %0d cycles", adr, waited);
        end
        rdat     = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wb_wr(input logic [3:0] adr, input logic [7:0] dat);
        logic [7:0] r;
        int         w;
        wb_access(1'b1, adr, dat, r, w);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] adr, input int exp);
        logic [7:0] r;
        int         w;
        wb_access(1'b0, adr, 8'h00, r, w);
        check(name, r, exp);
    endtask

    task automatic vid_rd(input int a, output logic [7:0] c, output logic [7:0] at);
        video_addr = 12'(a);
        @(posedge clk);
        #1;
        c  = video_char_data;
        at = video_attr_data;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        logic [7:0] c, a, r;
        int         n, bad_c, bad_a;

        rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 8'h00; wb_dat_i = 8'h00; video_addr = 12'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_ack", wb_ack_o, 0);
        check("rst_dat", wb_dat_o, 8'h00);
        check("rst_vchar", video_char_data, 8'h20);
        check("rst_vattr", video_attr_data, 8'h07);
        vid_rd(2399, c, a);
        check("vid2399_char", c, 8'h20);
        check("vid2399_attr", a, 8'h07);
        vid_rd(2400, c, a);
        check("vid2400_char", c, 8'h20);
        check("vid2400_attr", a, 8'h07);

        // Register table
        vecs.push_back('{1'b0, 4'h0, 8'h00, "ctrl_rst"});
        vecs.push_back('{1'b0, 4'h1, 8'h00, "curx_rst"});
        vecs.push_back('{1'b0, 4'h2, 8'h00, "cury_rst"});
        vecs.push_back('{1'b0, 4'h3, 8'h07, "attr_rst"});
        vecs.push_back('{1'b0, 4'h6, 8'h00, "ptrhi_rst"});
        vecs.push_back('{1'b0, 4'h7, 8'h00, "ptrlo_rst"});
        vecs.push_back('{1'b0, 4'h4, 8'h20, "char_at_cur_init"});
        vecs.push_back('{1'b0, 4'h5, 8'h07, "attr_at_cur_init"});
        vecs.push_back('{1'b0, 4'hA, 8'h00, "scroll_read"});
        vecs.push_back('{1'b1, 4'hB, 8'hFF, ""});
        vecs.push_back('{1'b0, 4'hB, 8'h00, "regB_read"});
        vecs.push_back('{1'b0, 4'hF, 8'h00, "regF_read"});
        vecs.push_back('{1'b1, 4'h1, 8'd200, ""});
        vecs.push_back('{1'b0, 4'h1, 8'd79, "curx_sat200"});
        vecs.push_back('{1'b1, 4'h1, 8'd80, ""});
        vecs.push_back('{1'b0, 4'h1, 8'd79, "curx_sat80"});
        vecs.push_back('{1'b1, 4'h2, 8'd30, ""});
        vecs.push_back('{1'b0, 4'h2, 8'd29, "cury_sat30"});
        vecs.push_back('{1'b1, 4'h2, 8'd0, ""});
        vecs.push_back('{1'b1, 4'h4, 8'h42, ""});
        vecs.push_back('{1'b0, 4'h1, 8'd0, "curx_wrap"});
        vecs.push_back('{1'b0, 4'h2, 8'd1, "cury_wrap"});
        vecs.push_back('{1'b1, 4'h4, 8'h43, ""});
        vecs.push_back('{1'b0, 4'h1, 8'd1, "curx_adv"});
        vecs.push_back('{1'b1, 4'h0, 8'h06, ""});
        vecs.push_back('{1'b0, 4'h0, 8'h06, "ctrl_rw"});
        vecs.push_back('{1'b1, 4'h0, 8'h00, ""});
        vecs.push_back('{1'b1, 4'h3, 8'h5A, ""});
        vecs.push_back('{1'b0, 4'h3, 8'h5A, "attr_rw"});
        vecs.push_back('{1'b1, 4'h6, 8'h12, ""});
        vecs.push_back('{1'b1, 4'h7, 8'h34, ""});
        vecs.push_back('{1'b0, 4'h6, 8'h12, "ptrhi_rw"});
        vecs.push_back('{1'b0, 4'h8, 8'h00, "ptr_oor_read"});
        vecs.push_back('{1'b0, 4'h7, 8'h34, "ptr_oor_noinc"});
        foreach (vecs[i]) begin
            if (vecs[i].we) wb_wr(vecs[i].adr, vecs[i].dat);
            else rd_chk(vecs[i].name, vecs[i].adr, int'(vecs[i].dat));
        end

        // Scroll-on-wrap at the last cell
        wb_wr(4'h3, 8'h07);
        wb_wr(4'h1, 8'd79);
        wb_wr(4'h2, 8'd29);
        wb_wr(4'h0, 8'h04);
        wb_wr(4'h4, 8'h41);
        check("wrap_busy_start", busy, 1);
        wait_idle(n);
        check("wrap_busy_cycles", n, (ROWS - 1) * COLS + 1 + COLS);
        vid_rd(28 * COLS + 79, c, a);
        check("wrap_A_char", c, 8'h41);
        check("wrap_A_attr", a, 8'h07);
        vid_rd(0, c, a);
        check("wrap_row1_moved", c, 8'h43);
        vid_rd(79, c, a);
        check("wrap_cell79_moved", c, 8'h20);
        bad_c = 0; bad_a = 0;
        for (int i = 29 * COLS; i < CELLS; i++) begin
            vid_rd(i, c, a);
            if (c != 8'h20) bad_c++;
            if (a != 8'h07) bad_a++;
        end
        check("wrap_row29_bad_chars", bad_c, 0);
        check("wrap_row29_bad_attrs", bad_a, 0);
        rd_chk("wrap_curx", 4'h1, 0);
        rd_chk("wrap_cury", 4'h2, 29);

        // Clear with stalled PTR read
        wb_wr(4'h3, 8'h1E);
        wb_wr(4'h6, 8'h00);
        wb_wr(4'h7, 8'h10);
        wb_wr(4'h0, 8'h01);
        wb_access(1'b0, 4'h8, 8'h00, r, n);
        check("clear_stall_cycles", n - 1, CELLS);
        check("clear_ptr_read", r, 8'h20);
        rd_chk("clear_ptr_inc", 4'h7, 8'h11);
        bad_c = 0; bad_a = 0;
        for (int i = 0; i < CELLS; i++) begin
            vid_rd(i, c, a);
            if (c != 8'h20) bad_c++;
            if (a != 8'h1E) bad_a++;
        end
        check("clear_bad_chars", bad_c, 0);
        check("clear_bad_attrs", bad_a, 0);

        // PTR at the last cell and past the end
        wb_wr(4'h6, 8'h09);
        wb_wr(4'h7, 8'h5F);
        wb_wr(4'h8, 8'h55);
        rd_chk("ptr_last_inc_lo", 4'h7, 8'h60);
        rd_chk("ptr_last_inc_hi", 4'h6, 8'h09);
        wb_wr(4'h8, 8'h77);
        rd_chk("ptr_end_noinc", 4'h7, 8'h60);
        rd_chk("ptr_end_read", 4'h9, 8'h00);
        vid_rd(2399, c, a);
        check("ptr_last_char", c, 8'h55);
        check("ptr_last_attr", a, 8'h1E);

        // Fill rows with row index, scroll by 3
        wb_wr(4'h6, 8'h00);
        wb_wr(4'h7, 8'h00);
        for (int i = 0; i < CELLS; i++) wb_wr(4'h8, 8'(i / COLS));
        wb_wr(4'h3, 8'h4F);
        wb_wr(4'hA, 8'd3);
        wait_idle(n);
        check("scroll3_busy_cycles", n, CELLS + 1);
        vid_rd(0, c, a);
        check("scroll3_row0", c, 3);
        vid_rd(26 * COLS + 40, c, a);
        check("scroll3_row26", c, 29);
        bad_c = 0; bad_a = 0;
        for (int i = 0; i < CELLS; i++) begin
            vid_rd(i, c, a);
            if (i < (ROWS - 3) * COLS) begin
                if (c != 8'(i / COLS + 3)) bad_c++;
                if (a != 8'h1E) bad_a++;
            end else begin
                if (c != 8'h20) bad_c++;
                if (a != 8'h4F) bad_a++;
            end
        end
        check("scroll3_bad_chars", bad_c, 0);
        check("scroll3_bad_attrs", bad_a, 0);

        // Reset in the middle of a COPY
        wb_wr(4'h0, 8'h06);
        wb_wr(4'hA, 8'd1);
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_vchar", video_char_data, 8'h20);
        check("abort_vattr", video_attr_data, 8'h07);
        rst = 1'b0;
        rd_chk("abort_ctrl", 4'h0, 8'h00);
        rd_chk("abort_curx", 4'h1, 8'h00);
        rd_chk("abort_cury", 4'h2, 8'h00);
        rd_chk("abort_attr", 4'h3, 8'h07);
        rd_chk("abort_ptrhi", 4'h6, 8'h00);
        rd_chk("abort_ptrlo", 4'h7, 8'h00);

        // Cursor overlay
        wb_wr(4'h1, 8'd5);
        wb_wr(4'h4, 8'h5A);
        rd_chk("ovl_curx_adv", 4'h1, 6);
        wb_wr(4'h1, 8'd5);
        wb_wr(4'h5, 8'h1E);
        rd_chk("ovl_attr_at_cur", 4'h5, 8'h1E);
        rd_chk("ovl_char_at_cur", 4'h4, 8'h5A);
        wb_wr(4'h7, 8'd6);
        wb_wr(4'h9, 8'h3C);
        vid_rd(5, c, a);
        check("ovl_off_attr", a, 8'h1E);
        wb_wr(4'h0, 8'h02);
        vid_rd(5, c, a);
        check("ovl_char", c, 8'h5A);
`ifdef CURSOR_OVERLAY_EN
        check("ovl_on_attr", a, 8'hE1);
`else
        check("ovl_on_attr", a, 8'h1E);
`endif
        vid_rd(6, c, a);
        check("ovl_neighbour_attr", a, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
